ifetch_queue: RTL and testbench



---
 rtl/ifetch_queue_if.sv | 36 +++
 rtl/ifetch_queue.sv | 143 ++++++++++++++
 tb/tb_ifetch_queue.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: bundles the pipeline-side and instruction-memory-side
// signals of the instruction prefetch queue.
//   stall, redirect, redirect_pc    : pipeline control into the queue
//   imem_req, imem_addr             : fetch request to instruction memory
//   imem_valid, imem_rdata          : response from instruction memory
//   inst_valid, inst, inst_pc,
//   inst_pc4, count                 : head entry and occupancy to decode
// The master modport is the queue itself; the slave modport is its environment.
interface ifetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          stall;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_valid;
    logic [31:0]   imem_rdata;
    logic          inst_valid;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    logic [31:0]   inst_pc4;
    logic [CW-1:0] count;

    modport master (
        input  stall, redirect, redirect_pc, imem_valid, imem_rdata,
        output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc4, count
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_valid, imem_rdata,
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc4, count
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction prefetch queue feeding the IF/ID register.
// Issues sequential word fetches (one outstanding at a time) to a
// variable-latency instruction memory, buffers returned words with their PCs
// in a DEPTH-entry circular buffer and presents the head entry to decode.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : ifetch_queue_if.master (pipeline control, imem request/response,
//          head entry outputs and occupancy)
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    ifetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]    state_r;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   req_pc_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic [31:0]   mem_pc_r   [DEPTH];
    logic [31:0]   mem_inst_r [DEPTH];

    logic          issue_s;
    logic          push_s;
    logic          pop_s;
    logic          head_valid_s;
    logic [31:0]   inst_s;
    logic [31:0]   inst_pc_s;

    // Handshake decisions for this cycle: request issue, response push, head pop.
    always_comb begin
        issue_s      = 1'b0;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        head_valid_s = 1'b0;
        if (rst) begin
            head_valid_s = 1'b0;
        end else begin
            head_valid_s = (count_r != {CW{1'b0}});
            // Issue only with free space: count cannot grow while a request is
            // outstanding, so the eventual push always has a slot.
            issue_s = (state_r == ST_IDLE) && (count_r < CW'(DEPTH)) && !bus.redirect;
            push_s  = (state_r == ST_WAIT) && bus.imem_valid && !bus.redirect;
            pop_s   = head_valid_s && !bus.stall && !bus.redirect;
        end
    end

    // Head entry view; zeros when the queue is empty or held in reset.
    always_comb begin
        inst_s    = 32'h0000_0000;
        inst_pc_s = 32'h0000_0000;
        if (head_valid_s) begin
            inst_s    = mem_inst_r[rd_ptr_r];
            inst_pc_s = mem_pc_r[rd_ptr_r];
        end else begin
            inst_s    = 32'h0000_0000;
            inst_pc_s = 32'h0000_0000;
        end
    end

    assign bus.imem_req   = issue_s;
    assign bus.imem_addr  = fetch_pc_r;
    assign bus.inst_valid = head_valid_s;
    assign bus.inst       = inst_s;
    assign bus.inst_pc    = inst_pc_s;
    assign bus.inst_pc4   = inst_pc_s + 32'd4;
    assign bus.count      = count_r;

    // Fetch FSM, fetch PC, pointers and occupancy; redirect flushes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= RESET_PC;
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
        end else if (bus.redirect) begin
            fetch_pc_r <= {bus.redirect_pc[31:2], 2'b00};
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            // An outstanding response must still be swallowed when it arrives.
            case (state_r)
                ST_IDLE:    state_r <= ST_IDLE;
                ST_WAIT:    state_r <= bus.imem_valid ? ST_IDLE : ST_DISCARD;
                ST_DISCARD: state_r <= bus.imem_valid ? ST_IDLE : ST_DISCARD;
                default:    state_r <= ST_IDLE;
            endcase
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        fetch_pc_r <= fetch_pc_r + 32'd4;
                        req_pc_r   <= fetch_pc_r;
                        state_r    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_valid) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    if (bus.imem_valid) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; entries need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_pc_r[wr_ptr_r]   <= req_pc_r;
            mem_inst_r[wr_ptr_r] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed self-checking bench for ifetch_queue.
// A simple memory responder inside the tick task answers each request one
// cycle later with rdata = addr ^ 32'hA5A5A5A5 when mem_en is set.
module tb_ifetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5_A5A5;

    logic clk;
    logic rst;

    int checks;
    int failures;

    logic        mem_en;
    logic        req_q;
    logic [31:0] addr_q;

    ifetch_queue_if #(.DEPTH(DEPTH)) bus ();

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: capture the request, pass a rising edge, then apply
    // the memory response at the falling edge and settle.
    task automatic tick();
        #1;
        req_q  = bus.imem_req;
        addr_q = bus.imem_addr;
        @(negedge clk);
        if (mem_en) begin
            bus.imem_valid = req_q;
            bus.imem_rdata = addr_q ^ KEY;
        end else begin
            bus.imem_valid = 1'b0;
            bus.imem_rdata = 32'h0000_0000;
        end
        #1;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        mem_en          = 1'b0;
        rst             = 1'b1;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0000_0000;
        bus.imem_valid  = 1'b0;
        bus.imem_rdata  = 32'h0000_0000;
        @(negedge clk);
        #1;
        tick();
        tick();

        // Reset state
        chk("rst_req",   {31'd0, bus.imem_req},   32'd0);
        chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_inst",  bus.inst,    32'h0);
        chk("rst_pc",    bus.inst_pc, 32'h0);
        chk("rst_count", {29'd0, bus.count}, 32'd0);

        // Sequential fetch with 1-cycle memory, no stall
        rst    = 1'b0;
        mem_en = 1'b1;
        #1;
        chk("seq_req0",  {31'd0, bus.imem_req}, 32'd1);
        chk("seq_addr0", bus.imem_addr, 32'h0);
        tick();
        chk("seq_wait_req", {31'd0, bus.imem_req}, 32'd0);
        tick();
        chk("seq_valid0", {31'd0, bus.inst_valid}, 32'd1);
        chk("seq_pc0",   bus.inst_pc,  32'h0);
        chk("seq_inst0", bus.inst,     32'hA5A5_A5A5);
        chk("seq_pc4_0", bus.inst_pc4, 32'h4);
        chk("seq_addr1", bus.imem_addr, 32'h4);
        tick();
        chk("seq_empty", {31'd0, bus.inst_valid}, 32'd0);
        tick();
        chk("seq_pc1",   bus.inst_pc, 32'h4);
        chk("seq_inst1", bus.inst,    32'hA5A5_A5A1);
        chk("seq_addr2", bus.imem_addr, 32'h8);
        tick();
        tick();
        chk("seq_pc2",   bus.inst_pc, 32'h8);
        chk("seq_inst2", bus.inst,    32'hA5A5_A5AD);
        chk("seq_addr3", bus.imem_addr, 32'hC);

        // Stall from reset: fill to DEPTH, then drain on consecutive cycles
        rst    = 1'b1;
        mem_en = 1'b0;
        tick();
        tick();
        rst       = 1'b0;
        bus.stall = 1'b1;
        mem_en    = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("stall_count", {29'd0, bus.count}, 32'd4);
        chk("stall_req",   {31'd0, bus.imem_req}, 32'd0);
        chk("stall_pc",    bus.inst_pc, 32'h0);
        bus.stall = 1'b0;
        tick();
        chk("drain_pc1",    bus.inst_pc, 32'h4);
        chk("drain_count1", {29'd0, bus.count}, 32'd3);
        chk("resume_req",   {31'd0, bus.imem_req}, 32'd1);
        chk("resume_addr",  bus.imem_addr, 32'h10);
        tick();
        chk("drain_pc2", bus.inst_pc, 32'h8);
        tick();
        // push and pop in the same cycle at count 2
        chk("pp_pc",    bus.inst_pc, 32'hC);
        chk("pp_count", {29'd0, bus.count}, 32'd2);
        tick();
        chk("resume_pc",   bus.inst_pc, 32'h10);
        chk("resume_inst", bus.inst,    32'hA5A5_A5B5);

        // Redirect while WAIT, late response dropped in DISCARD
        rst    = 1'b1;
        mem_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0043;
        chk("rdw_req", {31'd0, bus.imem_req}, 32'd0);
        tick();
        bus.redirect   = 1'b0;
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rdw_count", {29'd0, bus.count}, 32'd0);
        chk("rdw_disc_req", {31'd0, bus.imem_req}, 32'd0);
        tick();
        chk("rdw_drop_count", {29'd0, bus.count}, 32'd0);
        chk("rdw_drop_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rdw_req2",  {31'd0, bus.imem_req}, 32'd1);
        chk("rdw_addr",  bus.imem_addr, 32'h40);
        mem_en = 1'b1;
        tick();
        tick();
        chk("rdw_pc",    bus.inst_pc, 32'h40);
        chk("rdw_inst",  bus.inst,    32'hA5A5_A5E5);

        // Redirect coinciding with a response: data not enqueued
        mem_en = 1'b0;
        tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0100;
        bus.imem_valid  = 1'b1;
        bus.imem_rdata  = 32'h1234_5678;
        tick();
        bus.redirect = 1'b0;
        #1;
        chk("rdv_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rdv_count", {29'd0, bus.count}, 32'd0);
        chk("rdv_req",   {31'd0, bus.imem_req}, 32'd1);
        chk("rdv_addr",  bus.imem_addr, 32'h100);

        // Redirect during stall flushes a non-empty queue
        bus.stall = 1'b1;
        mem_en    = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("rds_fill", {29'd0, bus.count}, 32'd2);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        mem_en          = 1'b0;
        tick();
        bus.redirect = 1'b0;
        #1;
        chk("rds_count", {29'd0, bus.count}, 32'd0);
        chk("rds_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rds_addr",  bus.imem_addr, 32'h200);
        chk("rds_req",   {31'd0, bus.imem_req}, 32'd1);

        // Reset mid-WAIT with fetch_pc at 0x20, then a stray response
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_001C;
        tick();
        bus.redirect = 1'b0;
        #1;
        chk("rw_addr", bus.imem_addr, 32'h1C);
        tick();
        chk("rw_fpc", bus.imem_addr, 32'h20);
        rst = 1'b1;
        #1;
        chk("rw_rst_req",   {31'd0, bus.imem_req},   32'd0);
        chk("rw_rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        tick();
        rst            = 1'b0;
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 32'hCAFE_F00D;
        #1;
        chk("rw_addr_rst", bus.imem_addr, 32'h0);
        chk("rw_req",      {31'd0, bus.imem_req}, 32'd1);
        chk("rw_count",    {29'd0, bus.count}, 32'd0);
        chk("rw_valid",    {31'd0, bus.inst_valid}, 32'd0);
        tick();
        chk("rw_stray_count", {29'd0, bus.count}, 32'd0);
        chk("rw_wait_req",    {31'd0, bus.imem_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
